// File: rtl/sha2_round_engine.sv
// sha2_round_engine: SHA-256 / SHA-512 compression round loop, one round per
// clock, on-chip K ROM, optional feed-forward and output accept handshake.
// Ports: clock, clear (async, active-low); a..h_init, message_schedule_value,
// input_ready, output_accept in; a..h_final, message_schedule_index,
// output_ready, busy out.
module sha2_round_engine #(
  parameter int WORD_SIZE    = 32,
  parameter int FEED_FORWARD = 1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] a_init,
  input  logic [WORD_SIZE-1:0] b_init,
  input  logic [WORD_SIZE-1:0] c_init,
  input  logic [WORD_SIZE-1:0] d_init,
  input  logic [WORD_SIZE-1:0] e_init,
  input  logic [WORD_SIZE-1:0] f_init,
  input  logic [WORD_SIZE-1:0] g_init,
  input  logic [WORD_SIZE-1:0] h_init,
  input  logic [WORD_SIZE-1:0] message_schedule_value,
  input  logic                 input_ready,
  input  logic                 output_accept,
  output logic [WORD_SIZE-1:0] a_final,
  output logic [WORD_SIZE-1:0] b_final,
  output logic [WORD_SIZE-1:0] c_final,
  output logic [WORD_SIZE-1:0] d_final,
  output logic [WORD_SIZE-1:0] e_final,
  output logic [WORD_SIZE-1:0] f_final,
  output logic [WORD_SIZE-1:0] g_final,
  output logic [WORD_SIZE-1:0] h_final,
  output logic [$clog2((WORD_SIZE == 64) ? 80 : 64)-1:0] message_schedule_index,
  output logic                 output_ready,
  output logic                 busy
);

  localparam int W      = WORD_SIZE;
  localparam int ROUNDS = (W == 64) ? 80 : 64;
  localparam int IDX_W  = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

  localparam int S0A = (W == 64) ? 28 : 2;
  localparam int S0B = (W == 64) ? 34 : 13;
  localparam int S0C = (W == 64) ? 39 : 22;
  localparam int S1A = (W == 64) ? 14 : 6;
  localparam int S1B = (W == 64) ? 18 : 11;
  localparam int S1C = (W == 64) ? 41 : 25;

  generate
    if (W != 32 && W != 64) begin : g_bad_width
      $error("sha2_round_engine: WORD_SIZE must be 32 or 64");
    end
  endgenerate

  // SHA-256 constants are the upper halves of the first 64 SHA-512 ones.
  localparam logic [63:0] K_TAB [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd,
    64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019,
    64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe,
    64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
    64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
    64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
    64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210,
    64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
    64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
    64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
    64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
    64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910,
    64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
    64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
    64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
    64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9,
    64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207,
    64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
    64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493,
    64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
    64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // Element 0 is a, element 7 is h.
  logic [7:0][W-1:0] v_q, v_d;
  logic [7:0][W-1:0] ini_q, ini_d;
  logic [7:0][W-1:0] fin_q, fin_d;
  logic [7:0][W-1:0] ins, rnd;
  logic [W-1:0] kt, s0, s1, ch, maj, t1, t2;
  logic start;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x,
                                        input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  assign ins = {h_init, g_init, f_init, e_init,
                d_init, c_init, b_init, a_init};

  assign kt  = K_TAB[idx_q][63 -: W];
  assign s0  = rotr(v_q[0], S0A) ^ rotr(v_q[0], S0B) ^ rotr(v_q[0], S0C);
  assign s1  = rotr(v_q[4], S1A) ^ rotr(v_q[4], S1B) ^ rotr(v_q[4], S1C);
  assign ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
  assign maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
  assign t1  = v_q[7] + s1 + ch + kt + message_schedule_value;
  assign t2  = s0 + maj;
  assign rnd = {v_q[6], v_q[5], v_q[4], v_q[3] + t1,
                v_q[2], v_q[1], v_q[0], t1 + t2};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    v_d     = v_q;
    ini_d   = ini_q;
    fin_d   = fin_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: start = input_ready;
      RUN: begin
        v_d   = rnd;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d = '0;
          if (FEED_FORWARD != 0) begin
            state_d = ADD;
          end else begin
            state_d = DONE;
            fin_d   = rnd;
          end
        end
      end
      ADD: begin
        for (int i = 0; i < 8; i++) fin_d[i] = ini_q[i] + v_q[i];
        state_d = DONE;
      end
      DONE: begin
        // Accept together with a new request chains straight into RUN.
        if (output_accept) begin
          state_d = IDLE;
          start   = input_ready;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = RUN;
      v_d     = ins;
      ini_d   = ins;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      v_q     <= '0;
      ini_q   <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      v_q     <= v_d;
      ini_q   <= ini_d;
      fin_q   <= fin_d;
    end
  end

  assign a_final = fin_q[0];
  assign b_final = fin_q[1];
  assign c_final = fin_q[2];
  assign d_final = fin_q[3];
  assign e_final = fin_q[4];
  assign f_final = fin_q[5];
  assign g_final = fin_q[6];
  assign h_final = fin_q[7];

  assign message_schedule_index = idx_q;
  assign output_ready = (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == ADD);

endmodule

// File: tb/tb_sha2_round_engine.sv
// tb_sha2_round_engine: directed bench for sha2_round_engine with three
// instances (SHA-256 ff, SHA-256 raw, SHA-512 ff) on one clock and reset.
module tb_sha2_round_engine;

  localparam logic [7:0][31:0] H256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [7:0][31:0] H224 = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
  localparam logic [7:0][31:0] HXX = {
    32'h00000001, 32'hffffffff, 32'h80000000, 32'h13579bdf,
    32'h2468ace0, 32'hdeadbeef, 32'h89abcdef, 32'h01234567};
  localparam logic [7:0][63:0] H512 = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk, clear;
  logic go0, go1, go2, ac0, ac1, ac2;
  logic [7:0][31:0] iv32, f0, f1;
  logic [7:0][63:0] iv64, f2;
  logic [5:0] ix0, ix1;
  logic [6:0] ix2;
  logic rd0, rd1, rd2, by0, by1, by2;
  logic [31:0] w32 [64];
  logic [63:0] w64 [80];
  logic [31:0] m0, m1;
  logic [63:0] m2;
  int n_err, n_chk, sel;
  logic [63:0] s_idx, s_a;
  logic s_rdy, s_busy;

  assign m0 = w32[ix0];
  assign m1 = w32[ix1];
  assign m2 = w64[ix2];

  sha2_round_engine #(.WORD_SIZE(32), .FEED_FORWARD(1)) u_ff (
    .clock(clk), .clear(clear),
    .a_init(iv32[0]), .b_init(iv32[1]), .c_init(iv32[2]), .d_init(iv32[3]),
    .e_init(iv32[4]), .f_init(iv32[5]), .g_init(iv32[6]), .h_init(iv32[7]),
    .message_schedule_value(m0), .input_ready(go0), .output_accept(ac0),
    .a_final(f0[0]), .b_final(f0[1]), .c_final(f0[2]), .d_final(f0[3]),
    .e_final(f0[4]), .f_final(f0[5]), .g_final(f0[6]), .h_final(f0[7]),
    .message_schedule_index(ix0), .output_ready(rd0), .busy(by0));

  sha2_round_engine #(.WORD_SIZE(32), .FEED_FORWARD(0)) u_raw (
    .clock(clk), .clear(clear),
    .a_init(iv32[0]), .b_init(iv32[1]), .c_init(iv32[2]), .d_init(iv32[3]),
    .e_init(iv32[4]), .f_init(iv32[5]), .g_init(iv32[6]), .h_init(iv32[7]),
    .message_schedule_value(m1), .input_ready(go1), .output_accept(ac1),
    .a_final(f1[0]), .b_final(f1[1]), .c_final(f1[2]), .d_final(f1[3]),
    .e_final(f1[4]), .f_final(f1[5]), .g_final(f1[6]), .h_final(f1[7]),
    .message_schedule_index(ix1), .output_ready(rd1), .busy(by1));

  sha2_round_engine #(.WORD_SIZE(64), .FEED_FORWARD(1)) u_512 (
    .clock(clk), .clear(clear),
    .a_init(iv64[0]), .b_init(iv64[1]), .c_init(iv64[2]), .d_init(iv64[3]),
    .e_init(iv64[4]), .f_init(iv64[5]), .g_init(iv64[6]), .h_init(iv64[7]),
    .message_schedule_value(m2), .input_ready(go2), .output_accept(ac2),
    .a_final(f2[0]), .b_final(f2[1]), .c_final(f2[2]), .d_final(f2[3]),
    .e_final(f2[4]), .f_final(f2[5]), .g_final(f2[6]), .h_final(f2[7]),
    .message_schedule_index(ix2), .output_ready(rd2), .busy(by2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_idx  = '0;
    s_a    = '0;
    s_rdy  = 1'b0;
    s_busy = 1'b0;
    case (sel)
      0: begin s_idx = 64'(ix0); s_a = 64'(f0[0]); s_rdy = rd0; s_busy = by0; end
      1: begin s_idx = 64'(ix1); s_a = 64'(f1[0]); s_rdy = rd1; s_busy = by1; end
      2: begin s_idx = 64'(ix2); s_a = f2[0]; s_rdy = rd2; s_busy = by2; end
      default: ;
    endcase
  end

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference SHA-256 compression over the "abc" schedule.
  function automatic logic [7:0][31:0] ref256(input logic [7:0][31:0] iv,
                                              input bit ff);
    logic [7:0][31:0] v;
    logic [31:0] t1, t2;
    v = iv;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (r32(v[4], 6) ^ r32(v[4], 11) ^ r32(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K256[t] + w32[t];
      t2 = (r32(v[0], 2) ^ r32(v[0], 13) ^ r32(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v = {v[6], v[5], v[4], v[3] + t1, v[2], v[1], v[0], t1 + t2};
    end
    if (ff) for (int i = 0; i < 8; i++) v[i] = v[i] + iv[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0][31:0] got,
                      input logic [7:0][31:0] exp);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic drive(input int w, input logic g, input logic a);
    case (w)
      0: begin go0 = g; ac0 = a; end
      1: begin go1 = g; ac1 = a; end
      default: begin go2 = g; ac2 = a; end
    endcase
  endtask

  // Start a job (optionally together with accept) and follow it to DONE.
  // The start edge counts as cycle 1. At cycle 'poke' a stray request
  // with different inits is raised for one cycle while RUN is active.
  task automatic launch(input int w, input bit acc, input int poke);
    int r, ff, cyc, bi, bb, bf, mx;
    logic [63:0] a0;
    logic [7:0][31:0] keep;
    r = (w == 2) ? 80 : 64;
    ff = (w == 1) ? 0 : 1;
    sel = w;
    cyc = 0; bi = 0; bb = 0; bf = 0; mx = 0;
    a0 = '0;
    keep = iv32;
    drive(w, 1'b1, acc);
    for (int k = 1; k <= 200 && cyc == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin drive(w, 1'b0, 1'b0); a0 = s_a; end
      if (poke > 0 && k == poke) begin
        iv32 = ~keep; iv64 = ~iv64; drive(w, 1'b1, 1'b0);
      end
      if (poke > 0 && k == poke + 1) begin
        iv32 = keep; iv64 = ~iv64; drive(w, 1'b0, 1'b0);
      end
      if (s_idx != 64'((k <= r) ? k - 1 : 0)) bi++;
      if (s_busy != (k <= r + ff)) bb++;
      if (!s_rdy && s_a != a0) bf++;
      if (int'(s_idx) > mx) mx = int'(s_idx);
      if (s_rdy) cyc = k;
    end
    chk($sformatf("latency_u%0d", w), 64'(cyc), 64'(r + 1 + ff));
    chk($sformatf("idx_seq_u%0d", w), 64'(bi), 64'd0);
    chk($sformatf("busy_seq_u%0d", w), 64'(bb), 64'd0);
    chk($sformatf("final_hold_u%0d", w), 64'(bf), 64'd0);
    if (w == 2) chk("idx_max_u2", 64'(mx), 64'd79);
  endtask

  task automatic take(input int w);
    sel = w;
    drive(w, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 1'b0);
    chk($sformatf("acc_rdy_u%0d", w), 64'(s_rdy), 64'd0);
    chk($sformatf("acc_busy_u%0d", w), 64'(s_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0][31:0] e1;
    int bad;
    bit hit;
    n_err = 0; n_chk = 0; sel = 0;
    clear = 1'b0;
    go0 = 0; go1 = 0; go2 = 0; ac0 = 0; ac1 = 0; ac2 = 0;
    iv32 = H256;
    iv64 = H512;
    for (int t = 0; t < 64; t++) w32[t] = '0;
    for (int t = 0; t < 80; t++) w64[t] = '0;
    w32[0] = 32'h61626380;
    w32[15] = 32'h18;
    w64[0] = 64'h6162638000000000;
    w64[15] = 64'h18;
    for (int t = 16; t < 64; t++)
      w32[t] = (r32(w32[t-2], 17) ^ r32(w32[t-2], 19) ^ (w32[t-2] >> 10))
             + w32[t-7]
             + (r32(w32[t-15], 7) ^ r32(w32[t-15], 18) ^ (w32[t-15] >> 3))
             + w32[t-16];
    for (int t = 16; t < 80; t++)
      w64[t] = (r64(w64[t-2], 19) ^ r64(w64[t-2], 61) ^ (w64[t-2] >> 6))
             + w64[t-7]
             + (r64(w64[t-15], 1) ^ r64(w64[t-15], 8) ^ (w64[t-15] >> 7))
             + w64[t-16];

    #12;
    chk("rst_rdy", 64'({rd0, rd1, rd2}), 64'd0);
    chk("rst_busy", 64'({by0, by1, by2}), 64'd0);
    chk("rst_idx", 64'({ix0, ix1, ix2}), 64'd0);
    chk("rst_fin", 64'(f0[0] | f1[7]) | f2[0], 64'd0);
    @(negedge clk);
    clear = 1'b1;

    // SHA-256 "abc" with feed-forward
    launch(0, 1'b0, 0);
    e1 = ref256(H256, 1'b1);
    chk8("abc256", f0, e1);
    chk("abc256_a", 64'(f0[0]), 64'hba7816bf);
    chk("abc256_b", 64'(f0[1]), 64'h8f01cfea);
    chk("abc256_h", 64'(f0[7]), 64'hf20015ad);

    // Hold in DONE, stray request without accept is ignored
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) drive(0, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 1'b0);
      if (!rd0 || by0 || f0 != e1 || ix0 != 6'd0) bad++;
    end
    chk("done_hold", 64'(bad), 64'd0);

    // Accept + start together, stray request during RUN
    iv32 = H224;
    launch(0, 1'b1, 5);
    chk8("sha224", f0, ref256(H224, 1'b1));
    chk("sha224_a", 64'(f0[0]), 64'h23097d22);
    chk("sha224_g", 64'(f0[6]), 64'he36c9da7);

    // Raw working variables, no feed-forward
    iv32 = H256;
    launch(1, 1'b0, 0);
    chk8("raw256", f1, ref256(H256, 1'b0));
    chk("raw256_a", 64'(f1[0]), 64'h506e3058);
    take(1);

    // SHA-512 "abc"
    launch(2, 1'b0, 0);
    chk("abc512_a", f2[0], 64'hddaf35a193617aba);
    chk("abc512_h", f2[7], 64'h2a9ac94fa54ca49f);
    take(2);

    // Asynchronous abort at round 30
    take(0);
    iv32 = H256;
    sel = 0;
    hit = 1'b0;
    drive(0, 1'b1, 1'b0);
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 1'b0);
      if (ix0 == 6'd30) hit = 1'b1;
    end
    chk("abort_reach", 64'(hit), 64'd1);
    #2 clear = 1'b0;
    #1;
    chk("abort_fin0", 64'(f0), 64'd0);
    chk("abort_fin512", f2[0] | f2[7], 64'd0);
    chk("abort_idx", 64'(ix0), 64'd0);
    chk("abort_rdy", 64'(rd0), 64'd0);
    chk("abort_busy", 64'(by0), 64'd0);
    @(negedge clk);
    clear = 1'b1;
    launch(0, 1'b0, 0);
    chk8("post_abort", f0, ref256(H256, 1'b1));

    // Back-to-back jobs, each accepted on the first DONE cycle
    take(0);
    iv32 = H256;
    launch(0, 1'b0, 0);
    chk8("b2b_1", f0, ref256(H256, 1'b1));
    iv32 = H224;
    launch(0, 1'b1, 0);
    chk8("b2b_2", f0, ref256(H224, 1'b1));
    iv32 = HXX;
    launch(0, 1'b1, 0);
    chk8("b2b_3", f0, ref256(HXX, 1'b1));
    take(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
